// File: rtl/signed_seq_divider_if.sv
// Start/done handshake and operand/result bus of the signed sequential divider.
// Latency: none, this is wiring only.
// Backpressure: the master may only present start while ready is high.
interface signed_seq_divider_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          ready;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/signed_seq_divider.sv
// Signed DW/VW divider: sign-magnitude wrapper around restoring division, one quotient bit per clock.
// Latency: done pulses DW+1 edges after the accepting edge, or 1 edge for a zero divisor.
// Backpressure: ready is high only in IDLE; start while busy is ignored.
module signed_seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input logic                 clk,
  input logic                 rst,
  signed_seq_divider_if.slave bus
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state_q, state_d;
  // Dividend magnitude; quotient bits shift in at the LSB as it drains.
  logic [DW-1:0] dvd_q, dvd_d;
  // Partial remainder stays below |divisor| <= 2^(VW-1), so VW bits hold it.
  logic [VW-1:0] prem_q, prem_d;
  logic [VW:0]   dsr_q, dsr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sgn_q_q, sgn_q_d;
  logic          sgn_r_q, sgn_r_d;
  logic          dbz_pend_q, dbz_pend_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic          done_q, done_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] remo_q, remo_d;
  logic          dbz_flag_q, dbz_flag_d;
  logic          ovf_flag_q, ovf_flag_d;

  logic [VW:0]   dsr_ext;
  logic [VW:0]   shifted;

  assign bus.ready       = (state_q == IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_flag_q;
  assign bus.overflow    = ovf_flag_q;

  // Next-state, datapath step and result formatting.
  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    prem_d     = prem_q;
    dsr_d      = dsr_q;
    cnt_d      = cnt_q;
    sgn_q_d    = sgn_q_q;
    sgn_r_d    = sgn_r_q;
    dbz_pend_d = dbz_pend_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    remo_d     = remo_q;
    dbz_flag_d = dbz_flag_q;
    ovf_flag_d = ovf_flag_q;
    dsr_ext    = {bus.divisor[VW-1], bus.divisor};
    shifted    = {prem_q, dvd_q[DW-1]};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Flags describe the last completed operation until a new one is taken.
          dbz_flag_d = 1'b0;
          ovf_flag_d = 1'b0;
          if (bus.divisor == '0) begin
            dbz_pend_d = 1'b1;
            ovf_pend_d = 1'b0;
            state_d    = FIX;
          end else begin
            // Magnitudes: unsigned DW bits holds 2^(DW-1), VW+1 bits holds 2^(VW-1).
            dvd_d      = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
            dsr_d      = bus.divisor[VW-1] ? -dsr_ext : dsr_ext;
            sgn_q_d    = bus.dividend[DW-1] ^ bus.divisor[VW-1];
            sgn_r_d    = bus.dividend[DW-1];
            prem_d     = '0;
            cnt_d      = '0;
            dbz_pend_d = 1'b0;
            ovf_pend_d = (bus.dividend == {1'b1, {(DW-1){1'b0}}}) && (bus.divisor == '1);
            state_d    = CALC;
          end
        end
      end

      CALC: begin
        // Restoring step: subtract only when the shifted remainder covers the divisor.
        if (shifted >= dsr_q) begin
          prem_d = VW'(shifted - dsr_q);
          dvd_d  = {dvd_q[DW-2:0], 1'b1};
        end else begin
          prem_d = shifted[VW-1:0];
          dvd_d  = {dvd_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (dbz_pend_q) begin
          quot_d     = '0;
          remo_d     = '0;
          dbz_flag_d = 1'b1;
          ovf_flag_d = 1'b0;
        end else begin
          // -2^(DW-1)/-1 yields magnitude 2^(DW-1), which wraps to 8000h here.
          quot_d     = sgn_q_q ? -dvd_q : dvd_q;
          remo_d     = sgn_r_q ? -prem_q : prem_q;
          dbz_flag_d = 1'b0;
          ovf_flag_d = ovf_pend_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      prem_q     <= '0;
      dsr_q      <= '0;
      cnt_q      <= '0;
      sgn_q_q    <= 1'b0;
      sgn_r_q    <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      remo_q     <= '0;
      dbz_flag_q <= 1'b0;
      ovf_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      prem_q     <= prem_d;
      dsr_q      <= dsr_d;
      cnt_q      <= cnt_d;
      sgn_q_q    <= sgn_q_d;
      sgn_r_q    <= sgn_r_d;
      dbz_pend_q <= dbz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      remo_q     <= remo_d;
      dbz_flag_q <= dbz_flag_d;
      ovf_flag_q <= ovf_flag_d;
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Bench for signed_seq_divider: cycle model from integer division plus literal checks.
// Latency: model expects done DW+1 edges after acceptance, 1 edge for zero divisor.
// Backpressure: model ignores start while an operation is in flight.
module tb_signed_seq_divider;
  localparam int DW = 16;
  localparam int VW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  signed_seq_divider_if #(.DW(DW), .VW(VW)) ifc ();

  signed_seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Reference result from plain truncating integer arithmetic.
  function automatic void ref_div(input int a, input int b, output logic [15:0] q,
                                  output logic [7:0] r, output logic dbz, output logic ovf);
    int qi;
    int ri;
    if (b == 0) begin
      q = '0; r = '0; dbz = 1'b1; ovf = 1'b0;
    end else begin
      qi  = a / b;
      ri  = a % b;
      q   = 16'(qi);
      r   = 8'(ri);
      dbz = 1'b0;
      ovf = (a == -32768) && (b == -1);
    end
  endfunction

  // Cycle model: idle/busy countdown, result appears when the countdown expires.
  logic        m_ready, m_done, m_dbz, m_ovf;
  logic [15:0] m_q, p_q;
  logic [7:0]  m_r, p_r;
  logic        p_dbz, p_ovf;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1; m_done = 1'b0; m_q = '0; m_r = '0;
      m_dbz = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1; m_ready = 1'b1;
          m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ovf = p_ovf;
        end
      end else if (ifc.start) begin
        ref_div($signed(ifc.dividend), $signed(ifc.divisor), p_q, p_r, p_dbz, p_ovf);
        m_dbz = 1'b0; m_ovf = 1'b0; m_ready = 1'b0;
        m_cnt = p_dbz ? 1 : DW + 1;
      end
    end
  end

  // Every cycle, all outputs must agree with the model.
  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {ifc.ready, ifc.done, ifc.div_by_zero, ifc.overflow, ifc.quotient, ifc.remainder},
            {m_ready, m_done, m_dbz, m_ovf, m_q, m_r});
  end

  // Present an operation (DUT must be ready) and return edges from acceptance to done.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat);
    ifc.dividend = a;
    ifc.divisor  = b;
    ifc.start    = 1'b1;
    @(posedge clk); #1;
    ifc.start    = 1'b0;
    ifc.dividend = 16'($urandom);
    ifc.divisor  = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ifc.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] a, input logic [7:0] b,
                     input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                     input logic eovf, input int elat);
    int lat;
    do_op(a, b, lat);
    check({nm, " lat"}, lat, elat);
    check({nm, " q"}, ifc.quotient, eq);
    check({nm, " r"}, ifc.remainder, er);
    check({nm, " flags"}, {ifc.div_by_zero, ifc.overflow}, {edbz, eovf});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ai, bi, qi, ri;
    logic [15:0] a;
    logic [7:0]  b;
    bit ok;
    bit saw_done;

    rst = 1'b1; ifc.start = 1'b0; ifc.dividend = '0; ifc.divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("reset state", {ifc.ready, ifc.done, ifc.div_by_zero, ifc.overflow, ifc.quotient, ifc.remainder},
          {1'b1, 27'b0});

    // Basic and sign matrix; each op starts in the previous done cycle (back-to-back).
    lit("100/7",      16'd100,  8'd7,    16'd14,   8'd2,   1'b0, 1'b0, 17);
    check("b2b ready", ifc.ready, 1'b1);
    lit("-100/7",     16'hFF9C, 8'd7,    16'hFFF2, 8'hFE,  1'b0, 1'b0, 17);
    lit("100/-7",     16'd100,  8'hF9,   16'hFFF2, 8'h02,  1'b0, 1'b0, 17);
    lit("-100/-7",    16'hFF9C, 8'hF9,   16'h000E, 8'hFE,  1'b0, 1'b0, 17);
    lit("32767/-128", 16'h7FFF, 8'h80,   16'hFF01, 8'h7F,  1'b0, 1'b0, 17);
    lit("-32768/-128",16'h8000, 8'h80,   16'h0100, 8'h00,  1'b0, 1'b0, 17);
    lit("ovf",        16'h8000, 8'hFF,   16'h8000, 8'h00,  1'b0, 1'b1, 17);
    lit("dbz",        16'd1234, 8'd0,    16'h0000, 8'h00,  1'b1, 1'b0, 1);
    lit("clear",      16'd100,  8'd7,    16'd14,   8'd2,   1'b0, 1'b0, 17);

    // Second start at cycle 5 of the operation must be ignored.
    @(posedge clk); #1;
    ifc.dividend = 16'd100; ifc.divisor = 8'd7; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 4) begin ifc.dividend = 16'd9; ifc.divisor = 8'd3; ifc.start = 1'b1; end
      if (k == 5) ifc.start = 1'b0;
      if (ifc.done) begin lat = k; break; end
    end
    check("ignore lat", lat, 17);
    check("ignore q", ifc.quotient, 16'd14);
    check("ignore r", ifc.remainder, 8'd2);

    // Reset mid-calculation: everything clears and no done follows.
    @(posedge clk); #1;
    ifc.dividend = 16'd1000; ifc.divisor = 8'd3; ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort outs", {ifc.ready, ifc.done, ifc.div_by_zero, ifc.overflow, ifc.quotient, ifc.remainder},
          {1'b1, 27'b0});
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ifc.done) saw_done = 1'b1;
    end
    check("abort no done", saw_done, 1'b0);
    lit("50/5", 16'd50, 8'd5, 16'd10, 8'd0, 1'b0, 1'b0, 17);

    // Random sweep: identity and remainder-bound properties on top of the cycle model.
    for (int n = 0; n < 1000; n++) begin
      a = 16'($urandom);
      do b = 8'($urandom); while (b == 8'd0);
      if (a == 16'h8000 && b == 8'hFF) b = 8'd1;
      do_op(a, b, lat);
      ai = $signed(a);
      bi = $signed(b);
      qi = $signed(ifc.quotient);
      ri = $signed(ifc.remainder);
      ok = (lat == 17) && (qi * bi + ri == ai) &&
           ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)) &&
           (ri == 0 || ((ri < 0) == (ai < 0)));
      check("sweep props", ok, 1'b1);
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/signed_seq_divider.md
Name: signed_seq_divider

Overview:
- Sequential signed integer divider; the inverse operation to the team's signed Vedic multiplier.
- Divides a 16-bit signed dividend by an 8-bit signed divisor and returns a 16-bit signed quotient and an 8-bit signed remainder.
- Uses the same sign-magnitude scheme as the multiplier: take magnitudes, run unsigned restoring division one quotient bit per clock, then re-apply signs.
- Sits beside the multiplier in the arithmetic datapath and uses a start/done handshake.

Parameters:
DW, 16, dividend and quotient width (two's complement)
VW, 8, divisor and remainder width (two's complement)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only while ready=1
dividend  input  DW  signed dividend, captured on the accepting edge
divisor  input  VW  signed divisor, captured on the accepting edge
ready  output  1  high in IDLE only
done  output  1  one-cycle pulse when results are valid
quotient  output  DW  signed quotient, held until the next done
remainder  output  VW  signed remainder, held until the next done
div_by_zero  output  1  divisor was 0 for the completed operation
overflow  output  1  quotient not representable (-32768 / -1)

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; ready=1; done, quotient, remainder, div_by_zero and overflow all 0. Reset aborts an operation in progress and produces no done pulse.
- States: IDLE, CALC, FIX.
- IDLE, start=1, divisor!=0:
  - Latch |dividend| (DW-bit unsigned; 32768 must be representable).
  - Latch |divisor| (VW+1 bits unsigned; 128 must be representable).
  - Latch sign_q = dividend[DW-1]^divisor[DW-1 of divisor, i.e. VW-1]; latch sign_r = dividend[DW-1].
  - Clear the partial remainder and iteration counter. Clear div_by_zero and overflow. Go to CALC.
- IDLE, start=1, divisor==0: go directly to FIX with the dbz flag set. No iteration is performed.
- CALC runs DW cycles. Each edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder (VW+1 bits).
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - The counter increments; after the DW-th iteration, go to FIX.
- FIX (one edge): register the outputs, pulse done=1, return to IDLE.
  - quotient = sign_q ? -Qmag : Qmag, truncated to DW bits.
  - remainder = sign_r ? -Rmag : Rmag.
  - Truncating (round-toward-zero) division: the remainder sign follows the dividend, |remainder| < |divisor|, and |remainder| <= 127 always fits in VW.
  - overflow=1 iff dividend=-2^(DW-1) and divisor=-1; in that case quotient=16'h8000 (wrapped) and remainder=0.
  - Divide-by-zero: quotient=0, remainder=0, div_by_zero=1, overflow=0.
- Latency:
  - Normal: done is set on the 17th (DW+1) rising edge after the edge that accepts start.
  - Divide-by-zero: done is set on the 1st rising edge after the accepting edge.
- done lasts exactly one cycle. ready returns to 1 in the same cycle done is high, so a start in that cycle is accepted.
- start while ready=0 is ignored; the operands are not re-sampled and the operation in flight is unaffected.
- Operand inputs may change freely after the accepting edge.
- Outputs and flags hold their values between done pulses. The flags clear only when the next operation is accepted.

Test Plan:
- dividend=100, divisor=7, start 1 cycle -> done on the 17th edge; quotient=14, remainder=2, flags=0; ready low for 17 cycles.
- Sign matrix:
  - -100/7 -> q=-14, r=-2
  - 100/-7 -> q=-14, r=2
  - -100/-7 -> q=14, r=-2
  - 32767/-128 -> q=-255, r=127
  - -32768/-128 -> q=256, r=0
- Edge cases:
  - -32768/-1 -> overflow=1, q=16'h8000, r=0
  - 1234/0 -> done on the 1st edge after acceptance, div_by_zero=1, q=0, r=0
  - the next valid operation clears both flags
- Handshake:
  - start pulsed again at cycle 5 with different operands -> ignored; result matches the first operands.
  - start asserted in the done cycle -> accepted back-to-back.
- Assert rst at cycle 8 of CALC -> next cycle ready=1, all outputs 0, no done pulse. A new 50/5 operation afterwards -> q=10, r=0.
- Random sweep of 1000 operand pairs (divisor!=0) compared against a truncating reference model: q*divisor+r==dividend, |r|<|divisor|, sign(r)==sign(dividend) or r==0.
